// File: rtl/rotate_square_scan.sv
// rotate_square_scan: drives a multi-digit common-anode seven-segment display
// with a square glyph that walks a closed loop (upper squares left to right,
// lower squares right to left), in either rotate or bounce mode.
module rotate_square_scan #(
   parameter int DIGITS       = 4,
   parameter int STEP_BITS    = 26,
   parameter int REFRESH_BITS = 18
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          up,
   input  logic                          mode,
   output logic [DIGITS-1:0]             an,
   output logic [6:0]                    sseg,
   output logic [$clog2(2*DIGITS)-1:0]   pos,
   output logic                          tick
);

   localparam int NPOS = 2 * DIGITS;
   localparam int PW   = $clog2(NPOS);
   localparam int SW   = $clog2(DIGITS);

   localparam logic [PW-1:0] POS_LAST  = PW'(NPOS - 1);
   localparam logic [PW-1:0] POS_PENUL = PW'(NPOS - 2);
   localparam logic [PW-1:0] POS_SPLIT = PW'(DIGITS);
   localparam logic [SW-1:0] SCAN_LAST = SW'(DIGITS - 1);

   localparam logic [6:0] GLYPH_UPPER = 7'b0011100;
   localparam logic [6:0] GLYPH_LOWER = 7'b0100011;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   logic [STEP_BITS-1:0]    presc_q, presc_d;
   logic [REFRESH_BITS-1:0] refc_q, refc_d;
   logic [SW-1:0]           scan_q, scan_d;
   logic [PW-1:0]           pos_q, pos_d;
   logic                    dir_q, dir_d;
   logic [DIGITS-1:0]       an_q, an_d;
   logic [6:0]              sseg_q, sseg_d;
   logic                    tick_w;

   // Loop neighbours with wrap-around at the loop ends.
   function automatic logic [PW-1:0] pos_fwd(input logic [PW-1:0] p);
      return (p == POS_LAST) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PW-1:0] pos_rev(input logic [PW-1:0] p);
      return (p == '0) ? POS_LAST : p - 1'b1;
   endfunction

   // Digit that carries the square: upper half counts from the left,
   // lower half counts from the right.
   function automatic logic [PW-1:0] sq_digit(input logic [PW-1:0] p);
      if (p < POS_SPLIT) return (POS_SPLIT - 1'b1) - p;
      return p - POS_SPLIT;
   endfunction

   function automatic logic [6:0] glyph(input logic [PW-1:0] p);
      return (p < POS_SPLIT) ? GLYPH_UPPER : GLYPH_LOWER;
   endfunction

   // Reset suppresses the step strobe even if the prescaler is all-ones.
   assign tick_w = rst & en & (&presc_q);

   // Next-state logic for prescaler, scanner, position/direction and display.
   always_comb begin
      presc_d = presc_q;
      refc_d  = refc_q + 1'b1;
      scan_d  = scan_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      an_d    = ~(DIGITS'(1) << scan_q);
      sseg_d  = GLYPH_BLANK;

      if (en) presc_d = presc_q + 1'b1;

      if (&refc_q) scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;

      if (!mode) begin
         // Rotate: direction follows up continuously; only its value at the
         // tick edge (through dir_q) steers the step.
         dir_d = up;
         if (tick_w) pos_d = dir_q ? pos_fwd(pos_q) : pos_rev(pos_q);
      end else if (tick_w) begin
         // Bounce: turn around at the loop ends without repeating them.
         if (pos_q == POS_LAST && dir_q) begin
            dir_d = 1'b0;
            pos_d = POS_PENUL;
         end else if (pos_q == '0 && !dir_q) begin
            dir_d = 1'b1;
            pos_d = PW'(1);
         end else begin
            pos_d = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
         end
      end

      if (PW'(scan_q) == sq_digit(pos_q)) sseg_d = glyph(pos_q);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q <= '0;
         refc_q  <= '0;
         scan_q  <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b1;
         an_q    <= '1;
         sseg_q  <= GLYPH_BLANK;
      end else begin
         presc_q <= presc_d;
         refc_q  <= refc_d;
         scan_q  <= scan_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
      end
   end

   assign an   = an_q;
   assign sseg = sseg_q;
   assign pos  = pos_q;
   assign tick = tick_w;

endmodule

// File: tb/tb_rotate_square_scan.sv
// Testbench for rotate_square_scan (DIGITS=4, STEP_BITS=3, REFRESH_BITS=2).
module tb_rotate_square_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       mode = 1'b0;
   logic [3:0] an;
   logic [6:0] sseg;
   logic [2:0] pos;
   logic       tick;

   int total = 0;
   int bad = 0;
   bit chk_on = 0;
   bit seen_tick;

   // Reference state: plain integers following the behavioural rules.
   int m_pre, m_ref, m_scan, m_pos, m_dir;
   logic [3:0] m_an;
   logic [6:0] m_sseg;

   rotate_square_scan #(.DIGITS(4), .STEP_BITS(3), .REFRESH_BITS(2)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode),
      .an(an), .sseg(sseg), .pos(pos), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sq_digit(input int p);
      return (p < 4) ? 3 - p : p - 4;
   endfunction

   function automatic logic [6:0] glyph(input int p);
      return (p < 4) ? 7'b0011100 : 7'b0100011;
   endfunction

   task automatic model_reset();
      m_pre = 0; m_ref = 0; m_scan = 0; m_pos = 0; m_dir = 1;
      m_an = 4'hF; m_sseg = 7'h7F;
   endtask

   task automatic model_update(input bit r, input bit e, input bit u, input bit m);
      int  npos, ndir;
      bit  tk;
      if (!r) begin
         model_reset();
         return;
      end
      tk     = e && (m_pre == 7);
      m_an   = ~(4'b0001 << m_scan);
      m_sseg = (m_scan == sq_digit(m_pos)) ? glyph(m_pos) : 7'h7F;
      if (e) m_pre = (m_pre + 1) % 8;
      if (m_ref == 3) m_scan = (m_scan + 1) % 4;
      m_ref = (m_ref + 1) % 4;
      npos = m_pos;
      ndir = m_dir;
      if (!m) begin
         ndir = u;
         if (tk) npos = m_dir ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
      end else if (tk) begin
         if (m_pos == 7 && m_dir == 1) begin npos = 6; ndir = 0; end
         else if (m_pos == 0 && m_dir == 0) begin npos = 1; ndir = 1; end
         else npos = m_dir ? m_pos + 1 : m_pos - 1;
      end
      m_pos = npos;
      m_dir = ndir;
   endtask

   // One clock cycle: drive on the falling edge, compare, then advance the model.
   task automatic step(input bit r, input bit e, input bit u, input bit m);
      @(negedge clk);
      rst = r; en = e; up = u; mode = m;
      #1;
      seen_tick = tick;
      if (chk_on) begin
         chk("tick", tick, (r && e && m_pre == 7));
         chk("pos", pos, m_pos);
         chk("an", an, m_an);
         chk("sseg", sseg, m_sseg);
      end
      @(posedge clk);
      model_update(r, e, u, m);
   endtask

   task automatic run_to_tick(input bit e, input bit u, input bit m, output int n);
      n = 0;
      seen_tick = 0;
      while (!seen_tick && n < 40) begin
         step(1, e, u, m);
         n++;
      end
      if (!seen_tick) n = -1;
      #1;
   endtask

   initial begin
      int n, found, changes, ticks, guard;
      logic [3:0] prev;
      int bseq[11] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
      bit r, e, u, m;

      model_reset();
      // Reset held for three cycles
      step(0, 0, 1, 0);
      chk_on = 1;
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      #1;
      chk("rst_an", an, 4'b1111);
      chk("rst_sseg", sseg, 7'h7F);
      chk("rst_pos", pos, 3'd0);
      chk("rst_tick", tick, 1'b0);

      // Release: first anode appears one cycle later
      step(1, 0, 1, 0);
      #1;
      chk("release_an", an, 4'b1110);

      // Forward rotate
      run_to_tick(1, 1, 0, n);
      chk("first_tick_latency", n, 8);
      chk("fwd_pos_first", pos, 3'd1);
      for (int i = 0; i < 7; i++) begin
         run_to_tick(1, 1, 0, n);
         chk("fwd_interval", n, 8);
         chk("fwd_pos", pos, (i + 2) % 8);
      end

      // Upper square on the leftmost digit at pos 0
      step(1, 0, 1, 0);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1, 0, 1, 0);
         #1;
         if (an === 4'b0111) found = 1;
      end
      chk("scan3_found", found, 1);
      chk("scan3_sseg", sseg, 7'b0011100);

      // Reverse wrap from pos 0
      run_to_tick(1, 0, 0, n);
      chk("rev_interval", n, 8);
      chk("rev_wrap_pos", pos, 3'd7);

      // Pause: scanner keeps running, position frozen
      prev = an;
      changes = 0;
      ticks = 0;
      for (int k = 0; k < 20; k++) begin
         step(1, 0, 0, 0);
         ticks += seen_tick;
         #1;
         if (an !== prev) begin
            chk("pause_scan_order", an, {prev[2:0], prev[3]});
            changes++;
            prev = an;
         end
      end
      chk("pause_ticks", ticks, 0);
      chk("pause_pos", pos, 3'd7);
      chk("pause_scan_changes", changes, 5);

      // Forward to pos 4, lower square on rightmost digit
      for (int i = 0; i < 5; i++) run_to_tick(1, 1, 0, n);
      chk("fwd_to4_pos", pos, 3'd4);
      step(1, 0, 1, 0);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1, 0, 1, 0);
         #1;
         if (an === 4'b1110) found = 1;
      end
      chk("scan0_found", found, 1);
      chk("scan0_sseg", sseg, 7'b0100011);

      // Bounce from pos 5 with dir forward; up is ignored
      run_to_tick(1, 1, 0, n);
      chk("pre_bounce_pos", pos, 3'd5);
      for (int i = 0; i < 11; i++) begin
         run_to_tick(1, 1'($urandom_range(0, 1)), 1, n);
         chk("bounce_pos", pos, bseq[i]);
      end

      // en dropped while prescaler is all-ones
      guard = 0;
      while (m_pre != 7 && guard < 20) begin step(1, 1, 1, 0); guard++; end
      step(1, 0, 1, 0);
      chk("hold_no_tick", seen_tick, 1'b0);
      step(1, 1, 1, 0);
      chk("hold_tick_next", seen_tick, 1'b1);

      // Reset in the tick cycle
      guard = 0;
      while (m_pre != 7 && guard < 20) begin step(1, 1, 1, 0); guard++; end
      step(0, 1, 1, 0);
      #1;
      chk("midrst_pos", pos, 3'd0);
      step(1, 0, 1, 0);
      run_to_tick(1, 1, 0, n);
      chk("midrst_latency", n, 8);
      chk("midrst_pos_after", pos, 3'd1);

      // Randomized run against the model
      m = 0;
      for (int k = 0; k < 1500; k++) begin
         r = ($urandom_range(0, 99) != 0);
         e = ($urandom_range(0, 3) != 0);
         u = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) m = ~m;
         step(r, e, u, m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rotate_square_scan.md
# rotate_square_scan

Parametrised rotating-square display driver for a multi-digit, common-anode seven-segment display. A prescaled step tick moves a square glyph around a closed loop: the upper squares travel left to right, then the lower squares travel right to left. Rotate and bounce modes are supported. A free-running refresh scanner time-multiplexes the digits, so the block connects directly to board anode and segment pins.

## Interface
- DIGITS, 4: number of display digits; legal range ≥ 2.
- STEP_BITS, 26: prescaler width; one step occurs every 2^STEP_BITS enabled cycles.
- REFRESH_BITS, 18: refresh divider width; the scan digit advances every 2^REFRESH_BITS cycles.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  step enable; when low, the prescaler and position hold.
- up  in  1  direction in rotate mode: 1 = forward (clockwise), 0 = reverse.
- mode  in  1  0 = rotate (wrap-around), 1 = bounce (ping-pong between the loop ends).
- an  out  DIGITS  anode enables, active-low; an[0] is the rightmost digit.
- sseg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- pos  out  $clog2(2*DIGITS)  current loop position.
- tick  out  1  single-cycle step strobe.

## Operation
- **Loop positions:** there are 2*DIGITS positions, p = 0..2*DIGITS-1.
  - p < DIGITS: upper square (a,b,f,g lit, sseg = 7'b0011100) on digit DIGITS-1-p.
  - p ≥ DIGITS: lower square (c,d,e,g lit, sseg = 7'b0100011) on digit p-DIGITS.
- **Prescaler:** STEP_BITS-bit counter; increments only while en = 1.
  - tick = en AND (prescaler all-ones); the prescaler then wraps to 0.
- **Direction register dir:** 1 = forward; reset value 1.
  - mode = 0: dir <= up every cycle.
  - mode = 1: dir is changed only by the bounce rule.
- **On tick, mode = 0:** pos <= dir ? (pos+1) mod 2D : (pos-1) mod 2D.
  - Wrap-around: 2D-1 → 0 forward, 0 → 2D-1 reverse.
- **On tick, mode = 1:**
  - pos = 2D-1 and dir = 1: dir <= 0, pos <= 2D-2.
  - pos = 0 and dir = 0: dir <= 1, pos <= 1.
  - Otherwise: step in direction dir.
  - Endpoints are never repeated.
- **Mode change:** a mode change mid-run takes effect on the next tick. On a 1→0 change, dir reloads from up on the next cycle.
- **Refresh scanner:**
  - A REFRESH_BITS counter runs free and ignores en.
  - When it is all-ones, scan <= (scan = DIGITS-1) ? 0 : scan+1.
- **Output register:**
  - an <= ~(1 << scan).
  - sseg <= glyph(pos) if scan equals the square's digit, else 7'b1111111.
- **Reset** (rst = 0 at an edge):
  - prescaler, refresh counter, scan and pos are cleared to 0; dir is set to 1.
  - an = all ones, sseg = 7'b1111111, tick = 0.
  - Reset overrides en and tick in the same cycle, including mid-step.

## Timing
- tick is combinational from the prescaler and en; pos updates on the same edge at which tick = 1.
  - The new pos is visible in the following cycle.
- After reset release with en held high, the first tick occurs on the 2^STEP_BITS-th enabled cycle.
- an and sseg are registered and lag scan/pos by exactly one cycle.
  - The first non-all-ones an appears one cycle after reset release (an = ~1).
- en deasserted in the cycle the prescaler is all-ones: no tick; the prescaler holds at all-ones.
  - The tick fires on the next enabled cycle.
- up toggled between ticks: no effect until the next tick. Only the value at the tick edge matters, via dir.
- The refresh counter and scan continue while en = 0; the display stays lit with a frozen pos.

## Test plan
All scenarios use DIGITS = 4, STEP_BITS = 3, REFRESH_BITS = 2.
- **Reset:**
  - Hold rst = 0 for 3 cycles → an = 4'b1111, sseg = 7'h7F, pos = 0, tick = 0.
  - Release → an = 4'b1110 next cycle.
- **Forward rotate:** en = 1, up = 1, mode = 0.
  - tick every 8 cycles; pos runs 0,1,…,7,0.
  - When scan = 3 and pos = 0: an = 4'b0111, sseg = 7'b0011100.
  - When scan = 0 and pos = 4: an = 4'b1110, sseg = 7'b0100011.
- **Reverse wrap and pause:**
  - up = 0 from pos = 0 → pos = 7 on the next tick.
  - en = 0 for 20 cycles → no tick, pos frozen, an keeps scanning 1110→1101→1011→0111.
- **Bounce:** mode = 1 from pos = 5, dir = 1 → pos 6,7,6,5,…,1,0,1; no repeated endpoint.
- **Mid-operation reset:**
  - rst = 0 in the same cycle as tick → next cycle pos = 0, prescaler = 0, dir = 1.
  - After release, the first tick arrives 8 enabled cycles later.
